step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
Parametrised one-hot step sequencer, the next generation of the fixed 9-step one-hot stepper.
- Generalises step count to N, with a runtime-programmable active length and a programmable prescaler (step rate).
- Adds enable, direction, wrap/bounce modes, synchronous index load and an end-of-sequence pulse.
- Drives phase/strobe selection for downstream display or actuator logic.

Parameters:
- N, 9, number of one-hot outputs (N >= 2).
- IDX_W, $clog2(N), width of index, length and load fields.
- DIV_W, 8, prescaler width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; 0 freezes index and prescaler.
- dir  input  1  0 = count up, 1 = count down (wrap mode; seeds bounce direction).
- mode  input  1  0 = wrap, 1 = bounce (ping-pong).
- last_step  input  IDX_W  highest active index; values >= N clamp to N-1.
- div  input  DIV_W  advance once every div+1 enabled cycles.
- load  input  1  synchronous load strobe.
- load_idx  input  IDX_W  index loaded when load=1; clamped to the effective last_step.
- step  output  N  one-hot decode of idx.
- idx  output  IDX_W  current index (registered).
- wrap  output  1  one-cycle pulse on sequence end (wrap or reversal).

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-high on rst. Priority: rst > load > advance.
- Reset values: idx=0, step=1 (bit 0 set), wrap=0, prescaler count=0, internal direction dir_q=0.
- Effective last: L = min(last_step, N-1), evaluated every cycle.
- Prescaler:
  - Counter pc increments on each en=1 cycle.
  - tick=1 when en=1 and pc==div; pc then returns to 0.
  - div=0 gives tick every enabled cycle.
  - en=0 holds pc and idx.
- step is a combinational decode of the registered idx: exactly one bit set, step[idx]=1, zero extra latency. Bits above L are never asserted in steady state.
- Load: on load=1, idx <= min(load_idx, L), pc <= 0, dir_q <= dir, wrap <= 0. No advance that cycle, regardless of en.
- Advance on tick, wrap mode (mode=0, direction = dir input; dir_q follows dir each cycle):
  - up: idx==L -> 0 with wrap=1; else idx+1.
  - down: idx==0 -> L with wrap=1; else idx-1.
- Advance on tick, bounce mode (mode=1, direction = dir_q):
  - up at idx==L: idx <= L-1, dir_q <= 1, wrap=1.
  - down at idx==0: idx <= 1, dir_q <= 0, wrap=1.
  - otherwise idx moves one step in the dir_q direction.
  - L==0: idx stays 0 and wrap pulses on every tick.
- Out-of-range index (idx > L after last_step is reduced at runtime): the next tick sets idx <= 0 (up) or L (down), with wrap=1. No tick: idx holds.
- wrap is registered, high exactly one cycle, coincident with the new idx. Otherwise 0.
- Mode or dir changes take effect at the next tick. Mid-sequence they never cause a skip or double step.
- rst asserted mid-sequence forces reset values on the next edge, overriding load and tick.

Decomposition:
- Package stepper_pkg: mode constants MODE_WRAP=0 and MODE_BOUNCE=1; DIR_UP=0 and DIR_DOWN=1; an index-clamp function min(x, N-1).
- One sub-module, step_prescaler (DIV_W parameter; ports clk, rst, en, clr, div, tick), instantiated once. Load drives clr.
- Index/direction state and the one-hot decode stay in the top module.

Test Plan:
- Reset: N=9, rst high 2 cycles then low, en=0 -> idx=0, step=9'h001, wrap=0, held indefinitely.
- Wrap up: en=1, div=0, mode=0, dir=0, last_step=8 -> idx 0..8 then 0; step walks 001,002,...,100,001; wrap high only the cycle idx returns to 0 (every 9 cycles).
- Prescaler and down: div=2, dir=1, last_step=3, start idx=0 -> idx changes every 3 cycles: 0,3,2,1,0,3; wrap on each 0->3 transition.
- Bounce: mode=1, div=0, last_step=3, dir=0 at load of 0 -> idx 0,1,2,3,2,1,0,1; wrap at the idx=2 following 3 and at the idx=1 following 0; last_step=0 -> idx fixed 0, wrap every cycle.
- Load and clamp: running with last_step=5, load=1, load_idx=7 -> idx=5 next cycle, pc=0; load with en=1 the same cycle -> no additional advance; last_step=12 with N=9 -> behaves as 8.
- Runtime shrink and reset mid-run: idx=7, last_step changed to 4, dir=0 -> next tick idx=0 with wrap=1; rst asserted with load=1 and tick=1 -> idx=0, step=001, wrap=0.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared constants and index helpers for the one-hot step sequencer.
package stepper_pkg;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Clamp an index-like value to the highest legal index.
    function automatic int unsigned clamp_idx(input int unsigned x, input int unsigned max_idx);
        return (x > max_idx) ? max_idx : x;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: tick once every div+1 enabled cycles; clr restarts the count.
module step_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pc_q;
    logic [DIV_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        tick = en && !clr && (pc_q == div);
        if (clr || tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Parametrised one-hot step sequencer with wrap/bounce modes, prescaler,
// synchronous load and an end-of-sequence pulse.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned N     = 9,
    parameter int unsigned IDX_W = $clog2(N),
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [IDX_W-1:0] last_step,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic [N-1:0]     step,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [IDX_W-1:0] eff_last;
    logic             tick;
    logic             move_up;

    step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .div  (div),
        .tick (tick)
    );

    always_comb begin
        eff_last = IDX_W'(clamp_idx(32'(last_step), N - 1));
        idx_d    = idx_q;
        dir_d    = (mode == MODE_WRAP) ? dir : dir_q;
        wrap_d   = 1'b0;
        move_up  = ((mode == MODE_WRAP) ? dir : dir_q) == DIR_UP;
        if (load) begin
            idx_d = IDX_W'(clamp_idx(32'(load_idx), 32'(eff_last)));
            dir_d = dir;
        end else if (tick) begin
            if (idx_q > eff_last) begin
                // index stranded above a shrunken length: restart at the near end
                idx_d  = move_up ? '0 : eff_last;
                wrap_d = 1'b1;
            end else if (mode == MODE_WRAP) begin
                if (move_up) begin
                    idx_d  = (idx_q == eff_last) ? '0 : idx_q + IDX_W'(1);
                    wrap_d = (idx_q == eff_last);
                end else begin
                    idx_d  = (idx_q == '0) ? eff_last : idx_q - IDX_W'(1);
                    wrap_d = (idx_q == '0);
                end
            end else if (eff_last == '0) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else if (move_up && idx_q == eff_last) begin
                idx_d  = eff_last - IDX_W'(1);
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
            end else if (!move_up && idx_q == '0) begin
                idx_d  = IDX_W'(1);
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
            end else begin
                idx_d = move_up ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            dir_q  <= DIR_UP;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    assign step = N'(1) << idx_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: behavioural model plus directed literal checks.
module tb_step_sequencer;

    localparam int N     = 9;
    localparam int IDX_W = 4;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst, en, dir, mode, load;
    logic [IDX_W-1:0] last_step, load_idx;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     step;
    logic [IDX_W-1:0] idx;
    logic             wrap;

    int checks   = 0;
    int failures = 0;

    int m_idx   = 0;
    int m_pc    = 0;
    bit m_dir   = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_valid = 1'b0;

    step_sequencer #(.N(N), .IDX_W(IDX_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
        .last_step(last_step), .div(div), .load(load), .load_idx(load_idx),
        .step(step), .idx(idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sequence rules expressed as arithmetic on plain integers.
    always @(posedge clk) begin : model
        int l, ni, s;
        bit t, nd, nw, up;
        l  = (int'(last_step) > N - 1) ? N - 1 : int'(last_step);
        t  = en && (m_pc == int'(div)) && !load;
        ni = m_idx;
        nd = (mode == 1'b0) ? dir : m_dir;
        nw = 1'b0;
        up = (mode == 1'b0) ? !dir : !m_dir;
        s  = up ? 1 : -1;
        if (rst) begin
            ni = 0; nd = 1'b0;
            m_pc <= 0;
            m_valid <= 1'b1;
        end else if (load) begin
            ni = (int'(load_idx) > l) ? l : int'(load_idx);
            nd = dir;
            m_pc <= 0;
        end else begin
            if (en) m_pc <= t ? 0 : m_pc + 1;
            if (t) begin
                if (m_idx > l) begin
                    ni = up ? 0 : l; nw = 1'b1;
                end else if (mode == 1'b0) begin
                    ni = (m_idx + s + l + 1) % (l + 1);
                    nw = up ? (m_idx == l) : (m_idx == 0);
                end else if (l == 0) begin
                    ni = 0; nw = 1'b1;
                end else begin
                    ni = m_idx + s;
                    if (ni < 0 || ni > l) begin
                        ni = m_idx - s; nd = !m_dir; nw = 1'b1;
                    end
                end
            end
        end
        m_idx  <= ni;
        m_dir  <= nd;
        m_wrap <= nw;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_idx", int'(idx), m_idx);
            check("model_step", int'(step), 1 << m_idx);
            check("model_wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input string name, input int e_idx, input int e_wrap);
        check({name, "_idx"}, int'(idx), e_idx);
        check({name, "_step"}, int'(step), 1 << e_idx);
        check({name, "_wrap"}, int'(wrap), e_wrap);
    endtask

    task automatic do_load(input int li);
        load = 1'b1; load_idx = IDX_W'(li);
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
        last_step = 4'd8; load_idx = '0; div = '0;
        cyc(2);
        rst = 1'b0;
        cyc(5);
        pin("reset", 0, 0);

        // wrap up through all 9 steps
        en = 1'b1;
        cyc(8);  pin("wrap_up_top", 8, 0);
        cyc(1);  pin("wrap_up_ret", 0, 1);
        cyc(1);  pin("wrap_up_next", 1, 0);
        cyc(20);

        // prescaler div=2, counting down over length 4
        dir = 1'b1; div = 8'd2; last_step = 4'd3;
        do_load(0); pin("pre_load", 0, 0);
        cyc(2);  pin("pre_hold", 0, 0);
        cyc(1);  pin("pre_down_wrap", 3, 1);
        cyc(3);  pin("pre_2", 2, 0);
        cyc(3);  pin("pre_1", 1, 0);
        cyc(3);  pin("pre_0", 0, 0);
        cyc(3);  pin("pre_wrap2", 3, 1);

        // bounce over 0..3
        mode = 1'b1; div = '0; dir = 1'b0;
        do_load(0); pin("bnc_load", 0, 0);
        cyc(4);  pin("bnc_rev_top", 2, 1);
        cyc(2);  pin("bnc_bottom", 0, 0);
        cyc(1);  pin("bnc_rev_bot", 1, 1);
        last_step = 4'd0;
        cyc(1);  pin("bnc_l0_a", 0, 1);
        cyc(1);  pin("bnc_l0_b", 0, 1);
        cyc(3);

        // load clamp, no advance during load even with en=1
        mode = 1'b0; last_step = 4'd5;
        cyc(4);
        do_load(7); pin("ld_clamp", 5, 0);
        cyc(1);  pin("ld_then_wrap", 0, 1);
        div = 8'd2;
        cyc(2);
        do_load(2); pin("ld_pc_clr", 2, 0);
        cyc(2);  pin("ld_pc_hold", 2, 0);
        cyc(1);  pin("ld_pc_tick", 3, 0);
        div = '0;

        // last_step above N-1 behaves as N-1
        last_step = 4'd12;
        do_load(0);
        cyc(8);  pin("clamp12_top", 8, 0);
        cyc(1);  pin("clamp12_wrap", 0, 1);

        // mid-sequence direction change
        cyc(2);
        dir = 1'b1;
        cyc(1);  pin("dir_flip", 1, 0);
        cyc(1);  pin("dir_flip_0", 0, 0);
        dir = 1'b0;

        // runtime shrink, up then down
        last_step = 4'd8;
        do_load(7);
        en = 1'b0; last_step = 4'd4;
        cyc(2);  pin("shrink_hold", 7, 0);
        en = 1'b1;
        cyc(1);  pin("shrink_up", 0, 1);
        last_step = 4'd8; do_load(7);
        last_step = 4'd4; dir = 1'b1;
        cyc(1);  pin("shrink_dn", 4, 1);

        // reset beats load and tick
        dir = 1'b0; cyc(2);
        rst = 1'b1; load = 1'b1; load_idx = 4'd3;
        cyc(1);  pin("rst_prio", 0, 0);
        rst = 1'b0; load = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
